// File: rtl/arith_pkg.sv
// rtl/arith_pkg.sv - ALUop codes and operation type shared by the arithmetic block (ARITH_SLTU_EN enables OP_SLTU)
package arith_pkg;

    typedef logic [3:0] alu_op_t;

    localparam alu_op_t OP_AND  = 4'b0000;
    localparam alu_op_t OP_OR   = 4'b0001;
    localparam alu_op_t OP_ADD  = 4'b0010;
    localparam alu_op_t OP_SUB  = 4'b0110;
    localparam alu_op_t OP_SLT  = 4'b0111;
    localparam alu_op_t OP_SLTU = 4'b1000;
    localparam alu_op_t OP_NOR  = 4'b1100;

endpackage

// File: rtl/arith_core.sv
// rtl/arith_core.sv - combinational ALU datapath producing next result and signed overflow (ARITH_SLTU_EN adds SLTU)
module arith_core
    import arith_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  alu_op_t          ALUop,
    output logic [WIDTH-1:0] next_result,
    output logic             next_overflow
);

    logic [WIDTH-1:0] sum;
    logic [WIDTH-1:0] diff;
    logic             a_sign;
    logic             b_sign;

    assign sum    = a + b;
    assign diff   = a - b;
    assign a_sign = a[WIDTH-1];
    assign b_sign = b[WIDTH-1];

    // Operation decode; SLT uses a true signed compare so it stays correct when a-b overflows
    always_comb begin
        next_result   = '0;
        next_overflow = 1'b0;
        case (ALUop)
            OP_AND: next_result = a & b;
            OP_OR:  next_result = a | b;
            OP_NOR: next_result = ~(a | b);
            OP_ADD: begin
                next_result   = sum;
                next_overflow = (a_sign == b_sign) && (sum[WIDTH-1] != a_sign);
            end
            OP_SUB: begin
                next_result   = diff;
                next_overflow = (a_sign != b_sign) && (diff[WIDTH-1] != a_sign);
            end
            OP_SLT: next_result = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
`ifdef ARITH_SLTU_EN
            OP_SLTU: next_result = {{(WIDTH-1){1'b0}}, (a < b)};
`endif
            default: begin
                next_result   = '0;
                next_overflow = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/arithmetic_part.sv
// rtl/arithmetic_part.sv - registered ALU stage with 1-cycle latency around arith_core (ARITH_SLTU_EN passes through to the core)
module arithmetic_part
    import arith_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  alu_op_t          ALUop,
    input  logic             in_valid,
    output logic [WIDTH-1:0] result,
    output logic             out_valid,
    output logic             zero,
    output logic             overflow
);

    logic [WIDTH-1:0] next_result;
    logic             next_overflow;

    arith_core #(
        .WIDTH(WIDTH)
    ) u_core (
        .a            (a),
        .b            (b),
        .ALUop        (ALUop),
        .next_result  (next_result),
        .next_overflow(next_overflow)
    );

    // Capture a valid operation each cycle; hold the last result while in_valid is low
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            result    <= '0;
            zero      <= 1'b0;
            overflow  <= 1'b0;
            out_valid <= 1'b0;
        end else begin
            out_valid <= in_valid;
            if (in_valid) begin
                result   <= next_result;
                zero     <= (next_result == '0);
                overflow <= next_overflow;
            end
        end
    end

endmodule

// File: tb/tb_arithmetic_part.sv
// tb/tb_arithmetic_part.sv - self-checking bench for arithmetic_part against an arithmetic reference model (honours ARITH_SLTU_EN)
module tb_arithmetic_part;

    logic        clk;
    logic        reset;
    logic [31:0] a;
    logic [31:0] b;
    logic [3:0]  ALUop;
    logic        in_valid;
    logic [31:0] result;
    logic        out_valid;
    logic        zero;
    logic        overflow;

    int tests;
    int failed;

    logic [31:0] exp_result;
    logic        exp_zero;
    logic        exp_overflow;
    logic        exp_valid;

    arithmetic_part #(
        .WIDTH(32)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .a        (a),
        .b        (b),
        .ALUop    (ALUop),
        .in_valid (in_valid),
        .result   (result),
        .out_valid(out_valid),
        .zero     (zero),
        .overflow (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: integer arithmetic on sign-extended 64-bit values, overflow = true result out of 32-bit signed range
    function automatic void ref_op(input logic [31:0] x, input logic [31:0] y, input logic [3:0] op,
                                   output logic [31:0] r, output logic o);
        longint sx;
        longint sy;
        longint s;
        longint lim_hi;
        longint lim_lo;
        sx = longint'($signed(x));
        sy = longint'($signed(y));
        lim_hi = 64'sd2147483647;
        lim_lo = -64'sd2147483648;
        r = 32'd0;
        o = 1'b0;
        case (op)
            4'b0000: r = x & y;
            4'b0001: r = x | y;
            4'b1100: r = ~(x | y);
            4'b0010: begin
                s = sx + sy;
                r = s[31:0];
                o = (s > lim_hi) || (s < lim_lo);
            end
            4'b0110: begin
                s = sx - sy;
                r = s[31:0];
                o = (s > lim_hi) || (s < lim_lo);
            end
            4'b0111: r = (sx < sy) ? 32'd1 : 32'd0;
`ifdef ARITH_SLTU_EN
            4'b1000: r = (longint'(x) < longint'(y)) ? 32'd1 : 32'd0;
`endif
            default: begin
                r = 32'd0;
                o = 1'b0;
            end
        endcase
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        check({tag, ".result"}, result, exp_result);
        check({tag, ".zero"}, {31'd0, zero}, {31'd0, exp_zero});
        check({tag, ".overflow"}, {31'd0, overflow}, {31'd0, exp_overflow});
        check({tag, ".out_valid"}, {31'd0, out_valid}, {31'd0, exp_valid});
    endtask

    // Drive one operation, advance past the next rising edge, update the model and compare
    task automatic step(input string tag, input logic [31:0] x, input logic [31:0] y,
                        input logic [3:0] op, input logic v);
        logic [31:0] r;
        logic        o;
        a = x;
        b = y;
        ALUop = op;
        in_valid = v;
        @(posedge clk);
        #1;
        exp_valid = v;
        if (v) begin
            ref_op(x, y, op, r, o);
            exp_result = r;
            exp_overflow = o;
            exp_zero = (r == 32'd0);
        end
        check_all(tag);
    endtask

    initial begin
        logic [3:0] ops [8];
        logic [3:0] rop;
        tests = 0;
        failed = 0;
        exp_result = 32'd0;
        exp_zero = 1'b0;
        exp_overflow = 1'b0;
        exp_valid = 1'b0;
        ops[0] = 4'b0000; ops[1] = 4'b0001; ops[2] = 4'b0010; ops[3] = 4'b0110;
        ops[4] = 4'b0111; ops[5] = 4'b1100; ops[6] = 4'b1000; ops[7] = 4'b0011;

        reset = 1'b1;
        a = 32'd0;
        b = 32'd0;
        ALUop = 4'b0010;
        in_valid = 1'b1;
        #12;
        check_all("reset_state");
        reset = 1'b0;

        step("add_6_16", 32'd6, 32'd16, 4'b0010, 1'b1);
        check("add_6_16.literal", result, 32'd22);
        step("add_30_6", 32'd30, 32'd6, 4'b0010, 1'b1);
        check("add_30_6.literal", result, 32'd36);
        step("and_30_6", 32'd30, 32'd6, 4'b0000, 1'b1);
        check("and_30_6.literal", result, 32'd6);
        step("and_ones", 32'hFFFFFFFF, 32'hFFFFFFFF, 4'b0000, 1'b1);
        step("add_ones", 32'hFFFFFFFF, 32'hFFFFFFFF, 4'b0010, 1'b1);
        check("add_ones.literal", result, 32'hFFFFFFFE);
        step("sub_5_5", 32'd5, 32'd5, 4'b0110, 1'b1);
        check("sub_5_5.zero_literal", {31'd0, zero}, 32'd1);
        step("add_ovf", 32'h7FFFFFFF, 32'd1, 4'b0010, 1'b1);
        check("add_ovf.literal", {overflow, result[30:0]}, 32'h80000000);
        step("sub_ovf", 32'h80000000, 32'd1, 4'b0110, 1'b1);
        step("slt_neg", 32'h80000000, 32'd1, 4'b0111, 1'b1);
        check("slt_neg.literal", result, 32'd1);
        step("slt_pos", 32'd1, 32'h80000000, 4'b0111, 1'b1);
        check("slt_pos.literal", result, 32'd0);
        step("sltu_pair", 32'h80000000, 32'd1, 4'b1000, 1'b1);
        check("sltu_pair.literal", result, 32'd0);
        step("or", 32'hF0F00000, 32'h0000000F, 4'b0001, 1'b1);
        step("nor", 32'hF0F00000, 32'h0000000F, 4'b1100, 1'b1);
        step("bad_op", 32'h12345678, 32'h1, 4'b1111, 1'b1);
        step("add_pre_hold", 32'd100, 32'd23, 4'b0010, 1'b1);
        step("hold_1", 32'd1, 32'd1, 4'b0110, 1'b0);
        step("hold_2", 32'h7FFFFFFF, 32'd1, 4'b0010, 1'b0);
        check("hold.literal", result, 32'd123);

        // Reset asserted between edges with a valid op on the inputs
        step("pre_reset", 32'h7FFFFFFF, 32'h7FFFFFFF, 4'b0010, 1'b1);
        #2;
        reset = 1'b1;
        #1;
        exp_result = 32'd0;
        exp_zero = 1'b0;
        exp_overflow = 1'b0;
        exp_valid = 1'b0;
        check_all("async_reset");
        @(posedge clk);
        #1;
        check_all("reset_edge_discard");
        #2;
        reset = 1'b0;
        step("after_reset", 32'd9, 32'd4, 4'b0110, 1'b1);
        check("after_reset.literal", result, 32'd5);

        // Randomized back-to-back traffic
        for (int i = 0; i < 300; i++) begin
            logic [31:0] rx;
            logic [31:0] ry;
            rx = $urandom;
            ry = $urandom;
            case ($urandom_range(0, 3))
                0: ry = rx;
                1: ry = {~rx[31], rx[30:0]};
                default: ;
            endcase
            rop = ($urandom_range(0, 9) == 0) ? 4'($urandom) : ops[$urandom_range(0, 7)];
            step("random", rx, ry, rop, ($urandom_range(0, 4) != 0));
        end

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule

// File: doc/arithmetic_part.md
ARITHMETIC_PART -- requirements
Module: arithmetic_part

Interface
REQ-001 SHALL have parameter: WIDTH, default 32, operand/result bit width.
REQ-002 SHALL have port: clk  input  1  rising-edge clock.
REQ-003 SHALL have port: reset  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port: a  input  WIDTH  operand A.
REQ-005 SHALL have port: b  input  WIDTH  operand B.
REQ-006 SHALL have port: ALUop  input  4  operation select.
REQ-007 SHALL have port: in_valid  input  1  operands/ALUop valid this cycle.
REQ-008 SHALL have port: result  output  WIDTH  registered result.
REQ-009 SHALL have port: out_valid  output  1  result registered from a valid input.
REQ-010 SHALL have port: zero  output  1  registered result == 0.
REQ-011 SHALL have port: overflow  output  1  registered signed overflow (ADD/SUB only, else 0).

Function
REQ-012 SHALL decode ALUop: 0000 AND; 0001 OR; 0010 ADD; 0110 SUB (a-b); 0111 SLT signed (1 if a<b signed, else 0); 1100 NOR.
REQ-013 SHALL produce result 0, overflow 0 for any other ALUop code.
REQ-014 SHALL perform ADD/SUB modulo 2^WIDTH; carry-out discarded.
REQ-015 SHALL set overflow for ADD when a, b share a sign and the sum's sign differs; for SUB when a, b differ in sign and the difference's sign differs from a.
REQ-016 SHALL compute SLT from the true signed comparison, correct even when a-b overflows (e.g. 0x80000000 < 0x00000001 -> 1).
REQ-017 SHALL register result, zero, overflow on the rising clk edge when in_valid=1; 1-cycle latency.
REQ-018 SHALL hold result, zero, overflow unchanged when in_valid=0.
REQ-019 SHALL register out_valid <= in_valid every cycle.
REQ-020 SHALL have no backpressure; one operation accepted per cycle, back-to-back.

Reset
REQ-021 SHALL clear result, zero, overflow and out_valid to 0 immediately on reset assertion, independent of clk.
REQ-022 SHALL discard an operation presented during or in the cycle reset is asserted; first capture on the first rising edge with reset low.

Configuration
REQ-023 SHALL recognise macro ARITH_SLTU_EN: when defined, ALUop 1000 = SLTU (1 if a<b unsigned, else 0); when undefined, 1000 follows REQ-013 (result 0).

Structure
REQ-024 SHALL place ALUop code localparams (OP_AND, OP_OR, OP_ADD, OP_SUB, OP_SLT, OP_NOR, OP_SLTU) and a 4-bit alu_op_t typedef in shared package arith_pkg.
REQ-025 SHALL use one combinational sub-module arith_core (a, b, ALUop -> next result, overflow); arithmetic_part adds only the registers.

Verification
REQ-026 SHALL cover ADD: a=6, b=16, ALUop=0010 -> result 22, zero 0, overflow 0 one cycle later; then a=30, b=6 -> 36.
REQ-027 SHALL cover AND: a=30, b=6, ALUop=0000 -> 6; a=b=0xFFFFFFFF -> 0xFFFFFFFF; ADD of same -> 0xFFFFFFFE, overflow 0.
REQ-028 SHALL cover SUB/zero: a=5, b=5, ALUop=0110 -> result 0, zero 1; ADD a=0x7FFFFFFF, b=1 -> 0x80000000, overflow 1.
REQ-029 SHALL cover SLT: a=0x80000000, b=1, ALUop=0111 -> 1; a=1, b=0x80000000 -> 0; with ARITH_SLTU_EN, ALUop=1000, first pair -> 0.
REQ-030 SHALL cover hold/reset: in_valid=0 -> outputs hold, out_valid 0; reset asserted mid-stream between clock edges -> all outputs 0 before the next edge.
